ram8: RTL and testbench

- Eight-word register memory that sits directly downstream of the 8-way demultiplexer.
- The demux steers the single `load` strobe to one of eight word registers, selected by `address`.
- An 8-way, WIDTH-bit read multiplexer presents the addressed word on `out`.
- Basic storage stage of the memory hierarchy. RAM64 and larger are built by tiling this block.

---
 rtl/ram8_pkg.sv | 20 ++
 rtl/ram8_word_register.sv | 39 +++
 rtl/ram8.sv | 54 +++++
 tb/tb_ram8.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ram8_pkg.sv
// Shared constants for the ram8 storage stage and the larger RAMs tiled from it.
// Also holds the one-hot load steering helper.
package ram8_pkg;

  localparam int WORD_WIDTH      = 16;
  localparam int RAM8_ADDR_WIDTH = 3;
  localparam int RAM8_DEPTH      = 1 << RAM8_ADDR_WIDTH;

  // Route a single strobe onto the selected enable; all other enables stay low.
  function automatic logic [RAM8_DEPTH-1:0] demux8(
    input logic [RAM8_ADDR_WIDTH-1:0] sel,
    input logic                       d
  );
    logic [RAM8_DEPTH-1:0] en;
    en      = {RAM8_DEPTH{1'b0}};
    en[sel] = d;
    return en;
  endfunction

endpackage

// File: rtl/ram8_word_register.sv
// One stored word: loads on the rising clock edge when load is high,
// asynchronously cleared to zero by an active-high reset.
module word_register
  import ram8_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Next-state: take the new word only when loaded, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = in;
    end else begin
      data_d = data_q;
    end
  end

  // Word storage with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= {WIDTH{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign out = data_q;

endmodule

// File: rtl/ram8.sv
// Eight-word register memory: load demuxed by address into eight word registers,
// addressed word presented combinationally on out with no clock latency.
module ram8
  import ram8_pkg::*;
#(
  parameter int WIDTH      = WORD_WIDTH,
  parameter int ADDR_WIDTH = RAM8_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [WIDTH-1:0]      out
);

  logic [RAM8_DEPTH-1:0] load_en_s;
  logic [WIDTH-1:0]      words_s [RAM8_DEPTH];

  // Load steering: exactly one enable follows load, the rest are held low.
  always_comb begin
    load_en_s = {RAM8_DEPTH{1'b0}};
    load_en_s = demux8(address, load);
  end

  for (genvar i = 0; i < RAM8_DEPTH; i++) begin : g_word
    word_register #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk   (clk),
      .reset (reset),
      .in    (in),
      .load  (load_en_s[i]),
      .out   (words_s[i])
    );
  end

  // Read mux: no bypass of in, so a same-cycle write only shows after the edge.
  always_comb begin
    out = {WIDTH{1'b0}};
    case (address)
      3'd0:    out = words_s[0];
      3'd1:    out = words_s[1];
      3'd2:    out = words_s[2];
      3'd3:    out = words_s[3];
      3'd4:    out = words_s[4];
      3'd5:    out = words_s[5];
      3'd6:    out = words_s[6];
      3'd7:    out = words_s[7];
      default: out = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_ram8.sv
// Directed, table-driven self-checking bench for ram8.
module tb_ram8;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic        load;
  logic [2:0]  address;
  logic [15:0] dout;

  int checks   = 0;
  int failures = 0;

  ram8 dut (
    .clk     (clk),
    .reset   (reset),
    .in      (din),
    .load    (load),
    .address (address),
    .out     (dout)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        ld;
    logic [15:0] exp;   // out expected 1 unit after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [2:0] a, input logic [15:0] d,
                         input logic ld, input logic [15:0] e);
    vec_t v;
    v.name = name; v.addr = a; v.data = d; v.ld = ld; v.exp = e;
    vecs.push_back(v);
  endtask

  // Drive at the falling edge, clock one rising edge, sample 1 unit later.
  task automatic cycle(input logic [2:0] a, input logic [15:0] d, input logic ld);
    @(negedge clk);
    address = a; din = d; load = ld;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] pat;
    reset = 1'b1; load = 1'b0; din = 16'h0000; address = 3'd0;

    // Vector table: per-word writes, read-back, isolation, load-low.
    for (int a = 0; a < 8; a++) begin
      pat = 16'h1111 * 16'(a + 1);
      add_vec($sformatf("write_w%0d", a), 3'(a), pat, 1'b1, pat);
    end
    for (int a = 0; a < 8; a++) begin
      pat = 16'h1111 * 16'(a + 1);
      add_vec($sformatf("read_w%0d", a), 3'(a), 16'hDEAD, 1'b0, pat);
    end
    add_vec("isolate_write_w5", 3'd5, 16'hBEEF, 1'b1, 16'hBEEF);
    for (int a = 0; a < 8; a++) begin
      pat = (a == 5) ? 16'hBEEF : 16'h1111 * 16'(a + 1);
      add_vec($sformatf("isolate_read_w%0d", a), 3'(a), 16'h0000, 1'b0, pat);
    end
    for (int k = 0; k < 3; k++)
      add_vec($sformatf("load_low_w2_%0d", k), 3'd2, 16'h1234, 1'b0, 16'h3333);

    // Power-on reset: every address reads zero.
    #3;
    for (int a = 0; a < 8; a++) begin
      address = 3'(a); #1;
      check($sformatf("por_w%0d", a), dout, 16'h0000);
    end
    @(negedge clk); reset = 1'b0;

    // Fill with all ones, then pulse reset between edges.
    for (int a = 0; a < 8; a++) cycle(3'(a), 16'hFFFF, 1'b1);
    @(negedge clk); load = 1'b0; address = 3'd6; #1;
    check("fill_w6", dout, 16'hFFFF);
    reset = 1'b1; #1;
    check("async_clear_immediate", dout, 16'h0000);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a); #1;
      check($sformatf("clear_w%0d", a), dout, 16'h0000);
    end
    reset = 1'b0;

    foreach (vecs[i]) begin
      cycle(vecs[i].addr, vecs[i].data, vecs[i].ld);
      check(vecs[i].name, dout, vecs[i].exp);
    end

    // Same-cycle read/write: old value before the edge, new value after.
    cycle(3'd0, 16'h0001, 1'b1);
    @(negedge clk);
    address = 3'd0; din = 16'hA5A5; load = 1'b1;
    #9;
    check("rw_before_edge", dout, 16'h0001);
    @(posedge clk); #1;
    check("rw_after_edge", dout, 16'hA5A5);

    // Reset overrides load across two edges.
    @(negedge clk);
    reset = 1'b1; load = 1'b1; address = 3'd7; din = 16'h7777;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    load = 1'b0; #1;
    reset = 1'b0; #1;
    check("reset_over_load_w7", dout, 16'h0000);
    address = 3'd0; #1;
    check("reset_cleared_w0", dout, 16'h0000);

    // First write after reset works normally and does not touch neighbours.
    cycle(3'd3, 16'h4242, 1'b1);
    check("post_reset_write_w3", dout, 16'h4242);
    cycle(3'd4, 16'h0000, 1'b0);
    check("post_reset_w4", dout, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
